// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ctrl_seq microcode sequencer.
//   - default bus / address widths
//   - opcode constants (IR[7:4])
//   - sequencer state encoding
//   - strobe-vector bit positions used between ctrl_decode and ctrl_seq
package ctrl_pkg;

  localparam int CTRL_DW = 4;
  localparam int CTRL_AW = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_MAB = 4'h3;
  localparam logic [3:0] OP_MBA = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam int NSTROBE   = 8;
  localparam int SB_RA_RS1 = 0;
  localparam int SB_RA_RS2 = 1;
  localparam int SB_RA_WS1 = 2;
  localparam int SB_RB_RS1 = 3;
  localparam int SB_RB_RS2 = 4;
  localparam int SB_RB_WS1 = 5;
  localparam int SB_ALU_WS = 6;
  localparam int SB_OUT_LD = 7;

  typedef logic [NSTROBE-1:0] strobe_t;

  // ADD and SUB are the only instructions that sample alu_zero.
  function automatic logic is_arith(logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> strobe mapping.
// Ports:
//   opcode_i      current IR opcode field
//   exec_valid_i  high only in an enabled EXEC cycle; all outputs are 0 otherwise
//   strobe_o      one-hot-per-agent strobe vector (bit positions from ctrl_pkg)
//   alu_op_o      0 = add, 1 = sub
// Each opcode drives at most one bus writer (ra_ws1 / rb_ws1 / alu_ws), and
// gating everything on exec_valid_i keeps the bus idle outside EXEC.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       exec_valid_i,
  output strobe_t    strobe_o,
  output logic       alu_op_o
);

  always_comb begin
    strobe_o = '0;
    alu_op_o = 1'b0;
    if (exec_valid_i) begin
      case (opcode_i)
        OP_LDA: strobe_o[SB_RA_RS1] = 1'b1;
        OP_LDB: strobe_o[SB_RB_RS1] = 1'b1;
        OP_MAB: begin
          strobe_o[SB_RA_WS1] = 1'b1;
          strobe_o[SB_RB_RS2] = 1'b1;
        end
        OP_MBA: begin
          strobe_o[SB_RB_WS1] = 1'b1;
          strobe_o[SB_RA_RS2] = 1'b1;
        end
        OP_ADD: begin
          strobe_o[SB_ALU_WS] = 1'b1;
          strobe_o[SB_RA_RS2] = 1'b1;
        end
        OP_SUB: begin
          strobe_o[SB_ALU_WS] = 1'b1;
          strobe_o[SB_RA_RS2] = 1'b1;
          alu_op_o            = 1'b1;
        end
        OP_OUT: begin
          strobe_o[SB_RA_WS1] = 1'b1;
          strobe_o[SB_OUT_LD] = 1'b1;
        end
        // NOP, JMP, JZ, HLT and the unused A-E codes drive nothing.
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: microcode control sequencer feeding the register file.
// Steps FETCH -> DECODE -> EXEC (3 cycles per instruction), HLT parks in HALT
// until reset.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   en        run enable; 0 freezes state, pc, IR, z_flag and blanks strobes
//   rom_data  instruction word, combinational ROM read of pc_addr
//   alu_zero  ALU zero flag, sampled at the end of EXEC of ADD/SUB
//   pc_addr   program counter / ROM address
//   im        immediate field IR[DW-1:0]
//   ra_*/rb_* regA / regB load-from-im, load-from-bus, drive-bus strobes
//   alu_ws    ALU drives bus;  alu_op 0 = add, 1 = sub
//   out_ld    output latch captures bus
//   halted    sequencer is in HALT
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int DW = CTRL_DW,
  parameter int AW = CTRL_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW+3:0] rom_data,
  input  logic          alu_zero,
  output logic [AW-1:0] pc_addr,
  output logic [DW-1:0] im,
  output logic          ra_rs1,
  output logic          ra_rs2,
  output logic          ra_ws1,
  output logic          rb_rs1,
  output logic          rb_rs2,
  output logic          rb_ws1,
  output logic          alu_ws,
  output logic          alu_op,
  output logic          out_ld,
  output logic          halted
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [DW+3:0] ir_q;
  logic          z_q;

  logic [3:0]    opcode;
  logic [AW-1:0] jump_pc;
  logic          exec_valid;
  strobe_t       strobe;
  logic          alu_op_w;

  assign opcode  = ir_q[DW+3:DW];
  assign jump_pc = AW'(ir_q[DW-1:0]);

  // Strobes come only from registered state/IR; en is the sole gate, so
  // reset (which forces FETCH) or a stall blanks them immediately.
  assign exec_valid = en && (state_q == ST_EXEC);

  ctrl_decode u_decode (
    .opcode_i     (opcode),
    .exec_valid_i (exec_valid),
    .strobe_o     (strobe),
    .alu_op_o     (alu_op_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= rom_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          pc_q    <= pc_q + AW'(1);
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
          if (is_arith(opcode)) z_q <= alu_zero;
          // pc already points past this instruction; a taken jump overrides it.
          if ((opcode == OP_JMP) || ((opcode == OP_JZ) && z_q)) pc_q <= jump_pc;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign pc_addr = pc_q;
  assign im      = ir_q[DW-1:0];
  assign ra_rs1  = strobe[SB_RA_RS1];
  assign ra_rs2  = strobe[SB_RA_RS2];
  assign ra_ws1  = strobe[SB_RA_WS1];
  assign rb_rs1  = strobe[SB_RB_RS1];
  assign rb_rs2  = strobe[SB_RB_RS2];
  assign rb_ws1  = strobe[SB_RB_WS1];
  assign alu_ws  = strobe[SB_ALU_WS];
  assign out_ld  = strobe[SB_OUT_LD];
  assign alu_op  = alu_op_w;
  assign halted  = (state_q == ST_HALT);

endmodule
